systolic_ctrl: RTL and testbench
================================

# systolic_ctrl

Sequencer for the 3×3 output-stationary systolic multiplier built from `pu` cells.
- Holds operand matrices A and B, loaded word by word.
- On `start`, clears the array, then feeds skewed, zero-padded rows of A into the left edge and columns of B into the top edge.
- Snapshots the N×N accumulators once the last product has landed, and streams C = A·B out row-major over a valid/ready port.
- Sits between the host/load logic and the PU grid; it is the only driver of the array's edge inputs and array-local reset.

## Interface
- `BW`, 8, operand width; results are 2·BW.
- `N`, 3, array dimension (verified at 3).
- `CW`, $clog2(N), row/column index width (2 at N=3).
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin a multiply; honoured only in IDLE.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse after the final result beat.
- `ld_valid` in 1: operand write request.
- `ld_ready` out 1: high exactly in IDLE.
- `ld_sel` in 1: 0 = A, 1 = B.
- `ld_row`, `ld_col` in CW each: element index.
- `ld_data` in BW: element value.
- `arr_rst_n` out 1: synchronous active-low clear to every PU.
- `row_x` out N·BW: slice i drives x_i of PU(i,0).
- `col_y` out N·BW: slice j drives y_i of PU(0,j).
- `acc_i` in N·N·2BW: pu_o of PU(i,j) at slice i·N+j.
- `res_valid` out 1: result beat valid.
- `res_ready` in 1: consumer accepts.
- `res_data` out 2BW: C[i][j].
- `res_idx` out 2CW: {i, j} of the current beat.

## Operation
- States: IDLE → CLEAR → FEED → CAPTURE → OUTPUT → IDLE.
- **IDLE**
  - A write occurs when `ld_valid` & `ld_ready`.
  - A write with `ld_row` ≥ N or `ld_col` ≥ N is dropped silently.
  - Buffers persist across runs; reruns reuse them.
  - `start` in IDLE moves to CLEAR. A write in the same cycle as `start` is committed and is used by that run.
  - `start` outside IDLE is ignored. `ld_valid` outside IDLE is not accepted (`ld_ready`=0).
- **CLEAR** (1 cycle): `arr_rst_n`=0, which zeroes pu_o, x_o and y_o of every PU.
- **FEED** (3N−2 cycles, t = 0…3N−3)
  - row_x[i] = A[i][t−i] when 0 ≤ t−i < N, else 0.
  - col_y[j] = B[t−j][j] when 0 ≤ t−j < N, else 0.
  - Product A[i][k]·B[k][j] therefore meets at PU(i,j) in cycle k+i+j. The last product is accumulated at the end of t = 3N−3.
- **CAPTURE** (1 cycle): all N·N `acc_i` slices are registered into the result buffer. Edge inputs stay 0, so the array holds its values.
- **OUTPUT**
  - N·N beats, row-major, `res_idx` counting 0…N·N−1 encoded as {i, j}.
  - `res_valid` stays high and `res_data`/`res_idx` stay stable until `res_ready`.
  - After the last handshake: go to IDLE and pulse `done`.
- **Arithmetic**: results are modulo 2^(2BW), matching PU accumulator wrap. No overflow flag.
- **Reset** (any state, including mid-run): state IDLE, counters 0, buffers A/B/C 0.
  - `row_x`, `col_y`, `res_data`, `res_idx` = 0.
  - `res_valid`, `busy`, `done` = 0; `arr_rst_n` = 0.
  - `ld_ready` = 1 once in IDLE.
  - `arr_rst_n` is registered: it rises the first cycle after `rst_n` deasserts.

## Timing
- All outputs are registered except `ld_ready` and `busy`, which decode state.
- With `start` sampled at the end of cycle s (N=3):
  - CLEAR: s+1
  - FEED: s+2 … s+8
  - CAPTURE: s+9
  - First `res_valid`: s+10
  - With `res_ready`=1 throughout: beats s+10 … s+18, `done` and IDLE at s+19.
- Each cycle of `res_ready`=0 during OUTPUT adds one cycle to the run.
- `start` may be asserted in the same cycle `done` is high (already IDLE). The next run then begins CLEAR at the following cycle.

## Test plan
- **Identity**: A=I, B={1..9} row-major, `res_ready`=1 → beats idx 0…8 carry 1…9; `done` at s+19.
- **General**: A={1..9}, B={9..1} → C = {30,24,18, 84,69,54, 138,114,90}.
- **Wrap**: all elements 255 → every C = 195075 mod 65536 = 64003.
- **Backpressure**: `res_ready` toggling 1/0 each cycle → data/idx held while stalled, each value exactly once, `done` at s+27.
- **Ignored inputs**:
  - `start` pulsed during FEED/OUTPUT → no effect.
  - `ld_valid` while busy → no write.
  - `ld_row`=3 write in IDLE → buffers unchanged; next result identical.
- **Reset mid-FEED**: `rst_n` low at s+5 → all outputs at reset values, `arr_rst_n` low. After release:
  - `busy`=0.
  - A rerun yields all-zero C, since the buffers were cleared by the reset.
  - Reloading then restores correct results.

Source files
------------

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic multiplier: holds A/B, feeds skewed edges, streams C row-major.
// Start-to-first-result 10 cycles at N=3; result beats hold until res_ready, operand writes accepted only in IDLE.
module systolic_ctrl #(
   parameter int BW = 8,
   parameter int N  = 3,
   parameter int CW = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic                  ld_sel,
   input  logic [CW-1:0]         ld_row,
   input  logic [CW-1:0]         ld_col,
   input  logic [BW-1:0]         ld_data,
   output logic                  arr_rst_n,
   output logic [N*BW-1:0]       row_x,
   output logic [N*BW-1:0]       col_y,
   input  logic [N*N*2*BW-1:0]   acc_i,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [2*BW-1:0]       res_data,
   output logic [2*CW-1:0]       res_idx
);
   localparam int RW = 2 * BW;
   localparam int NN = N * N;
   localparam int TW = $clog2(NN + 3 * N);
   localparam logic [TW-1:0] FEED_LAST = TW'(3 * N - 3);
   localparam logic [TW-1:0] OUT_LAST  = TW'(NN - 1);
   localparam logic [CW:0]   N_IDX     = (CW + 1)'(N);

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, CAPTURE, OUTPUT} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]   a_q [N][N];
   logic [BW-1:0]   a_d [N][N];
   logic [BW-1:0]   b_q [N][N];
   logic [BW-1:0]   b_d [N][N];
   logic [RW-1:0]   c_q [NN];
   logic [RW-1:0]   c_d [NN];
   logic            done_q, done_d;
   logic            arr_rst_n_q, arr_rst_n_d;
   logic [N*BW-1:0] row_x_q, row_x_d;
   logic [N*BW-1:0] col_y_q, col_y_d;
   logic            res_valid_q, res_valid_d;
   logic [RW-1:0]   res_data_q, res_data_d;
   logic [2*CW-1:0] res_idx_q, res_idx_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      c_d        = c_q;
      done_d     = 1'b0;
      row_x_d    = '0;
      col_y_d    = '0;
      res_data_d = '0;
      res_idx_d  = '0;

      unique case (state_q)
         IDLE: begin
            if (ld_valid && ({1'b0, ld_row} < N_IDX) && ({1'b0, ld_col} < N_IDX)) begin
               if (ld_sel) b_d[ld_row][ld_col] = ld_data;
               else        a_d[ld_row][ld_col] = ld_data;
            end
            if (start) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            state_d = FEED;
            cnt_d   = '0;
         end
         FEED: begin
            if (cnt_q == FEED_LAST) begin
               state_d = CAPTURE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         CAPTURE: begin
            for (int m = 0; m < NN; m++) c_d[m] = acc_i[m*RW +: RW];
            state_d = OUTPUT;
            cnt_d   = '0;
         end
         OUTPUT: begin
            if (res_valid_q && res_ready) begin
               if (cnt_q == OUT_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + TW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      arr_rst_n_d = (state_d != CLEAR);
      res_valid_d = (state_d == OUTPUT);

      // Edge lane i carries element k at feed step i+k, which gives the diagonal skew with zero padding.
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < N; k++) begin
            if (state_d == FEED && cnt_d == TW'(i + k)) begin
               row_x_d[i*BW +: BW] = a_q[i][k];
               col_y_d[i*BW +: BW] = b_q[k][i];
            end
         end
      end

      // c_d already holds the freshly captured grid on the CAPTURE->OUTPUT edge.
      if (state_d == OUTPUT) begin
         for (int m = 0; m < NN; m++) begin
            if (cnt_d == TW'(m)) begin
               res_data_d = c_d[m];
               res_idx_d  = {CW'(m / N), CW'(m % N)};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_q         <= '{default: '0};
         b_q         <= '{default: '0};
         c_q         <= '{default: '0};
         done_q      <= 1'b0;
         arr_rst_n_q <= 1'b0;
         row_x_q     <= '0;
         col_y_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         done_q      <= done_d;
         arr_rst_n_q <= arr_rst_n_d;
         row_x_q     <= row_x_d;
         col_y_q     <= col_y_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_idx_q   <= res_idx_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign ld_ready  = (state_q == IDLE);
   assign done      = done_q;
   assign arr_rst_n = arr_rst_n_q;
   assign row_x     = row_x_q;
   assign col_y     = col_y_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_idx   = res_idx_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: a behavioural 3x3 PU grid closes the loop, results are compared against matrix products.
module tb_systolic_ctrl;
   localparam int BW = 8;
   localparam int N  = 3;
   localparam int CW = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic                 busy, done, ld_ready, arr_rst_n, res_valid;
   logic                 ld_valid = 1'b0;
   logic                 ld_sel = 1'b0;
   logic [CW-1:0]        ld_row = '0;
   logic [CW-1:0]        ld_col = '0;
   logic [BW-1:0]        ld_data = '0;
   logic [N*BW-1:0]      row_x, col_y;
   logic [N*N*2*BW-1:0]  acc_i;
   logic                 res_ready = 1'b0;
   logic [2*BW-1:0]      res_data;
   logic [2*CW-1:0]      res_idx;

   systolic_ctrl #(.BW(BW), .N(N), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
      .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data),
      .arr_rst_n(arr_rst_n), .row_x(row_x), .col_y(col_y), .acc_i(acc_i),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // PU grid: x moves right, y moves down, each cell accumulates x*y modulo 2^16.
   logic [7:0]  gx   [3][3];
   logic [7:0]  gy   [3][3];
   logic [15:0] gacc [3][3];

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            logic [7:0] xin, yin;
            xin = (j == 0) ? row_x[i*8 +: 8] : gx[i][(j == 0) ? 0 : j-1];
            yin = (i == 0) ? col_y[j*8 +: 8] : gy[(i == 0) ? 0 : i-1][j];
            if (!arr_rst_n) begin
               gx[i][j]   <= '0;
               gy[i][j]   <= '0;
               gacc[i][j] <= '0;
            end else begin
               gx[i][j]   <= xin;
               gy[i][j]   <= yin;
               gacc[i][j] <= gacc[i][j] + ({8'd0, xin} * {8'd0, yin});
            end
         end
      end
   end

   always_comb begin
      acc_i = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            acc_i[(i*3+j)*16 +: 16] = gacc[i][j];
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0]  cur_a [9];
   logic [7:0]  cur_b [9];
   logic [15:0] exp_c [9];

   function automatic void ref_mul();
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            int sum;
            sum = 0;
            for (int k = 0; k < 3; k++) sum += int'(cur_a[i*3+k]) * int'(cur_b[k*3+j]);
            exp_c[i*3+j] = 16'(sum);
         end
      end
   endfunction

   task automatic load();
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 9; k++) begin
            ld_valid = 1'b1;
            ld_sel   = s[0];
            ld_row   = CW'(k / 3);
            ld_col   = CW'(k % 3);
            ld_data  = (s == 0) ? cur_a[k] : cur_b[k];
            step();
         end
      end
      ld_valid = 1'b0;
   endtask

   // mode 0: ready always, 1: ready on even offsets from start, 2: random ready.
   task automatic run(input int mode, input int exp_lat, input bit disturb, input string tag);
      int s, beats, done_at, rel;
      logic [15:0] got_d [9];
      logic [3:0]  got_i [9];
      logic        pv, pr;
      logic [15:0] pd;
      logic [3:0]  pi;
      start = 1'b1;
      s = cyc;
      step();
      start = 1'b0;
      check({tag, " clear arr_rst_n"}, 32'(arr_rst_n), 0);
      check({tag, " busy"}, 32'(busy), 1);
      check({tag, " ld_ready busy"}, 32'(ld_ready), 0);
      beats = 0; done_at = -1; pv = 0; pr = 0; pd = 0; pi = 0;
      for (int c = 0; c < 80 && done_at < 0; c++) begin
         rel = cyc - s;
         case (mode)
            0:       res_ready = 1'b1;
            1:       res_ready = (rel % 2 == 0);
            default: res_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (disturb && rel >= 3 && rel <= 15) begin
            start = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0;
            ld_row = '0; ld_col = '0; ld_data = 8'h55;
         end else begin
            start = 1'b0; ld_valid = 1'b0;
         end
         if (pv && !pr) begin
            check({tag, " stall valid"}, 32'(res_valid), 1);
            check({tag, " stall data"}, 32'(res_data), 32'(pd));
            check({tag, " stall idx"}, 32'(res_idx), 32'(pi));
         end
         if (res_valid && res_ready && beats < 9) begin
            got_d[beats] = res_data;
            got_i[beats] = res_idx;
            beats++;
         end
         if (done) done_at = rel;
         pv = res_valid; pr = res_ready; pd = res_data; pi = res_idx;
         if (done_at < 0) step();
      end
      start = 1'b0; ld_valid = 1'b0; res_ready = 1'b0;
      check({tag, " beats"}, 32'(beats), 9);
      for (int k = 0; k < beats; k++) begin
         check({tag, " data"}, 32'(got_d[k]), 32'(exp_c[k]));
         check({tag, " idx"}, 32'(got_i[k]), 32'({CW'(k / 3), CW'(k % 3)}));
      end
      if (exp_lat >= 0) check({tag, " done latency"}, 32'(done_at), 32'(exp_lat));
      check({tag, " idle at done"}, 32'(busy), 0);
   endtask

   typedef struct packed {
      logic [8:0][7:0]  a;
      logic [8:0][7:0]  b;
      logic [8:0][15:0] c;
      logic [7:0]       mode;
      logic [7:0]       lat;
   } vec_t;

   vec_t vt [4];
   int   gen_c [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

   initial begin
      for (int k = 0; k < 9; k++) begin
         vt[0].a[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
         vt[0].b[k] = 8'(k + 1);
         vt[0].c[k] = 16'(k + 1);
         vt[1].a[k] = 8'(k + 1);
         vt[1].b[k] = 8'(9 - k);
         vt[1].c[k] = 16'(gen_c[k]);
         vt[2].a[k] = 8'd255;
         vt[2].b[k] = 8'd255;
         vt[2].c[k] = 16'd64003;
         vt[3].a[k] = 8'(k + 1);
         vt[3].b[k] = 8'(9 - k);
         vt[3].c[k] = 16'(gen_c[k]);
      end
      vt[0].mode = 0; vt[0].lat = 19;
      vt[1].mode = 0; vt[1].lat = 19;
      vt[2].mode = 0; vt[2].lat = 19;
      vt[3].mode = 1; vt[3].lat = 27;

      rst_n = 1'b0;
      repeat (3) step();
      check("rst busy", 32'(busy), 0);
      check("rst done", 32'(done), 0);
      check("rst res_valid", 32'(res_valid), 0);
      check("rst arr_rst_n", 32'(arr_rst_n), 0);
      check("rst row_x", 32'(row_x), 0);
      check("rst col_y", 32'(col_y), 0);
      check("rst res_data", 32'(res_data), 0);
      check("rst res_idx", 32'(res_idx), 0);
      check("rst ld_ready", 32'(ld_ready), 1);
      rst_n = 1'b1;
      step();
      check("arr_rst_n release", 32'(arr_rst_n), 1);

      for (int v = 0; v < 4; v++) begin
         for (int k = 0; k < 9; k++) begin
            cur_a[k] = vt[v].a[k];
            cur_b[k] = vt[v].b[k];
            exp_c[k] = vt[v].c[k];
         end
         load();
         run(int'(vt[v].mode), int'(vt[v].lat), 1'b0, $sformatf("vec%0d", v));
         step();
         check("done pulse width", 32'(done), 0);
      end

      // General operands still loaded: stray start/ld_valid while busy must not disturb anything.
      run(0, 19, 1'b1, "disturb");
      run(0, 19, 1'b0, "after disturb");
      ld_valid = 1'b1; ld_sel = 1'b0; ld_row = 2'd3; ld_col = 2'd0; ld_data = 8'hAA; step();
      ld_sel = 1'b1; ld_row = 2'd1; ld_col = 2'd3; step();
      ld_valid = 1'b0;
      run(0, 19, 1'b0, "bad index");

      // Write committed in the same cycle as start is used by that run.
      cur_a[0] = 8'd7;
      ref_mul();
      ld_valid = 1'b1; ld_sel = 1'b0; ld_row = 2'd0; ld_col = 2'd0; ld_data = 8'd7;
      run(0, 19, 1'b0, "write with start");

      begin : reset_mid_feed
         int s;
         start = 1'b1;
         s = cyc;
         step();
         start = 1'b0;
         while (cyc - s < 5) step();
         rst_n = 1'b0;
         step();
         check("midrst busy", 32'(busy), 0);
         check("midrst arr_rst_n", 32'(arr_rst_n), 0);
         check("midrst row_x", 32'(row_x), 0);
         check("midrst col_y", 32'(col_y), 0);
         check("midrst res_valid", 32'(res_valid), 0);
         check("midrst done", 32'(done), 0);
         rst_n = 1'b1;
         step();
         check("midrst release busy", 32'(busy), 0);
         check("midrst release arr_rst_n", 32'(arr_rst_n), 1);
      end
      for (int k = 0; k < 9; k++) begin
         cur_a[k] = '0;
         cur_b[k] = '0;
      end
      ref_mul();
      run(0, 19, 1'b0, "cleared buffers");
      for (int k = 0; k < 9; k++) begin
         cur_a[k] = vt[1].a[k];
         cur_b[k] = vt[1].b[k];
      end
      ref_mul();
      load();
      run(0, 19, 1'b0, "reload");

      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 9; k++) begin
            cur_a[k] = 8'($urandom_range(0, 255));
            cur_b[k] = 8'($urandom_range(0, 255));
         end
         ref_mul();
         load();
         run(2, -1, 1'b0, $sformatf("rand%0d", r));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
